// File: rtl/memory_arbiter_pkg.sv
// State encodings and small helpers for the six-client memory arbiter.
package memory_arbiter_pkg;
    import memory_mux_pkg::*;

    localparam int NUM_CLIENTS = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    function automatic logic [5:0] onehot6(input logic [2:0] idx);
        logic [5:0] v;
        v = '0;
        if (idx < 3'd6) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [2:0] owner_sel(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = MUX_TRAVERSAL;
            3'd1:    code = MUX_EXECUTE;
            3'd2:    code = MUX_CELL;
            3'd3:    code = MUX_INCR;
            3'd4:    code = MUX_EQUAL;
            3'd5:    code = MUX_EDIT;
            default: code = MUX_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/memory_mux_pkg.sv
// Select codes shared by the memory mux and everything that drives its select.
package memory_mux_pkg;

    localparam logic [2:0] MUX_TRAVERSAL = 3'd0;
    localparam logic [2:0] MUX_EXECUTE   = 3'd1;
    localparam logic [2:0] MUX_CELL      = 3'd2;
    localparam logic [2:0] MUX_INCR      = 3'd3;
    localparam logic [2:0] MUX_EQUAL     = 3'd4;
    localparam logic [2:0] MUX_EDIT      = 3'd5;
    // Code 7 parks the mux on its default input, which holds execute low.
    localparam logic [2:0] MUX_IDLE      = 3'd7;

endpackage

// File: rtl/memory_arbiter_rr_pick6.sv
// Round-robin picker: first set request searching upward from last+1, wrapping after bit 5.
module rr_pick6 (
    input  logic [5:0] req,
    input  logic [2:0] last,
    output logic       valid,
    output logic [2:0] index
);
    logic [2:0] start;
    logic [3:0] cand;

    always_comb begin
        start = (last >= 3'd5) ? 3'd0 : last + 3'd1;
        valid = 1'b0;
        index = 3'd0;
        cand  = 4'd0;
        // Walk from farthest to nearest so the nearest hit is the one that sticks.
        for (int k = 5; k >= 0; k--) begin
            cand = {1'b0, start} + 4'(k);
            if (cand >= 4'd6) cand = cand - 4'd6;
            if (req[cand[2:0]]) begin
                valid = 1'b1;
                index = cand[2:0];
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Six-client round-robin memory arbiter with drain wait and sticky hold timeout.
module memory_arbiter
    import memory_mux_pkg::*;
    import memory_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 1024,
    parameter int HOLD_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req,
    input  logic       mem_ready,
    output logic [2:0] sel,
    output logic [5:0] grant,
    output logic       busy,
    output logic       timeout
);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e        state_q;
    logic [2:0]        owner_q;
    logic [2:0]        last_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              timeout_q;
    logic              armed_q;
    logic [2:0]        sel_q;
    logic [5:0]        grant_q;
    logic              busy_q;
    logic              pick_valid;
    logic [2:0]        pick_idx;

    rr_pick6 u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;

    // armed_q holds off arbitration for the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 3'd0;
            last_q    <= 3'd5;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            armed_q   <= 1'b0;
            sel_q     <= MUX_IDLE;
            grant_q   <= 6'd0;
            busy_q    <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (armed_q && pick_valid) begin
                        state_q <= ST_OWN;
                        owner_q <= pick_idx;
                        last_q  <= pick_idx;
                        hold_q  <= '0;
                        sel_q   <= owner_sel(pick_idx);
                        grant_q <= onehot6(pick_idx);
                        busy_q  <= 1'b1;
                    end
                end
                ST_OWN: begin
                    hold_q <= hold_d;
                    if (hold_d == HOLD_MAX) timeout_q <= 1'b1;
                    if (!req[owner_q]) begin
                        grant_q <= 6'd0;
                        if (mem_ready) begin
                            state_q <= ST_IDLE;
                            sel_q   <= MUX_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (mem_ready) begin
                        state_q <= ST_IDLE;
                        sel_q   <= MUX_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sel_q   <= MUX_IDLE;
                    grant_q <= 6'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sel     = sel_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: vector table, scoreboard queue, hand-written corner sequences.
module tb_memory_arbiter;

    logic       clk;
    logic       rst;
    logic [5:0] req;
    logic       mem_ready;
    logic [2:0] sel;
    logic [5:0] grant;
    logic       busy;
    logic       timeout;

    int checks;
    int errors;

    typedef struct {
        logic [5:0] req;
        logic       rdy;
        logic [2:0] sel;
        logic [5:0] grant;
        logic       busy;
        logic       timeout;
    } vec_t;

    typedef struct {
        logic [2:0] sel;
        logic [5:0] grant;
        logic       busy;
        logic       timeout;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    memory_arbiter #(
        .MAX_HOLD (8),
        .HOLD_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mem_ready (mem_ready),
        .sel       (sel),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [2:0] s, input logic [5:0] g, input logic b,
                                input logic t, input string n);
        exp_t e;
        e.sel = s; e.grant = g; e.busy = b; e.timeout = t; e.name = n;
        return e;
    endfunction

    function automatic void add(input logic [5:0] r, input logic rd, input logic [2:0] s,
                                input logic [5:0] g, input logic b, input logic t);
        vec_t v;
        v.req = r; v.rdy = rd; v.sel = s; v.grant = g; v.busy = b; v.timeout = t;
        vecs.push_back(v);
    endfunction

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: actual=empty required=entry");
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (sel !== e.sel || grant !== e.grant || busy !== e.busy || timeout !== e.timeout) begin
            errors++;
            $display("FAIL %s: actual sel=%0d grant=%b busy=%b timeout=%b required sel=%0d grant=%b busy=%b timeout=%b",
                     e.name, sel, grant, busy, timeout, e.sel, e.grant, e.busy, e.timeout);
        end else begin
            $display("ok   %s: sel=%0d grant=%b busy=%b timeout=%b", e.name, sel, grant, busy, timeout);
        end
    endtask

    task automatic drive(input logic [5:0] r, input logic rd, input exp_t e);
        @(negedge clk);
        req = r;
        mem_ready = rd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [5:0] oh;
        logic [5:0] r;
        int         o;

        checks = 0;
        errors = 0;
        req = 6'd0;
        mem_ready = 1'b1;
        rst = 1'b0;

        // req, rdy -> sel, grant, busy, timeout after the next edge
        add(6'b100001, 1, 3'd7, 6'b000000, 0, 0); // first edge after release: no grant
        add(6'b100001, 1, 3'd0, 6'b000001, 1, 0); // last=5 -> client 0
        add(6'b100001, 1, 3'd0, 6'b000001, 1, 0);
        add(6'b100000, 1, 3'd7, 6'b000000, 0, 0); // release, mem ready -> IDLE
        add(6'b100000, 1, 3'd5, 6'b100000, 1, 0);
        add(6'b000000, 0, 3'd5, 6'b000000, 1, 0); // DRAIN x3
        add(6'b100000, 0, 3'd5, 6'b000000, 1, 0); // reassert ignored
        add(6'b000000, 0, 3'd5, 6'b000000, 1, 0);
        add(6'b000000, 1, 3'd7, 6'b000000, 0, 0);
        add(6'b000100, 1, 3'd2, 6'b000100, 1, 0);
        add(6'b000100, 1, 3'd2, 6'b000100, 1, 0);
        add(6'b000000, 1, 3'd7, 6'b000000, 0, 0);
        add(6'b111111, 1, 3'd3, 6'b001000, 1, 0); // last=2 -> 3
        add(6'b110111, 1, 3'd7, 6'b000000, 0, 0);
        add(6'b110111, 1, 3'd4, 6'b010000, 1, 0);
        add(6'b000000, 0, 3'd4, 6'b000000, 1, 0);
        add(6'b000001, 1, 3'd7, 6'b000000, 0, 0); // leave DRAIN, req not taken this edge
        add(6'b000001, 1, 3'd0, 6'b000001, 1, 0);
        add(6'b000000, 1, 3'd7, 6'b000000, 0, 0);

        @(posedge clk);
        #2;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].rdy,
                  mk(vecs[i].sel, vecs[i].grant, vecs[i].busy, vecs[i].timeout, $sformatf("vec%0d", i)));
        end

        // Hold client 1 for 20 cycles with MAX_HOLD = 8.
        drive(6'b000010, 1, mk(3'd1, 6'b000010, 1, 0, "hold_grant"));
        for (int k = 1; k < 20; k++) begin
            drive(6'b000010, 1, mk(3'd1, 6'b000010, 1, (k >= 8), $sformatf("hold%0d", k)));
        end
        drive(6'b000000, 1, mk(3'd7, 6'b000000, 0, 1, "hold_release"));
        drive(6'b000000, 1, mk(3'd7, 6'b000000, 0, 1, "timeout_sticky"));

        // Reset asserted mid-OWN must clear outputs without a clock edge.
        drive(6'b111111, 1, mk(3'd2, 6'b000100, 1, 1, "pre_reset_own"));
        #2;
        rst = 1'b0;
        #1;
        exp_q.push_back(mk(3'd7, 6'b000000, 0, 0, "async_reset"));
        check_out();
        @(posedge clk);
        #2;
        rst = 1'b1;

        drive(6'b111111, 1, mk(3'd7, 6'b000000, 0, 0, "rr_arm"));
        for (int n = 0; n < 7; n++) begin
            o = n % 6;
            oh = 6'd1 << o;
            drive(6'b111111, 1, mk(3'(o), oh, 1, 0, $sformatf("rr_grant%0d", n)));
            r = 6'b111111 & ~oh;
            drive(r, 1, mk(3'd7, 6'b000000, 0, 0, $sformatf("rr_release%0d", n)));
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 1024, the owner-hold cycle count at which timeout sets.
REQ-002 SHALL have parameter HOLD_W, default 16, the hold counter width (2^HOLD_W > MAX_HOLD).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  6  per-client request, held while the client wants memory; bit0 traversal, bit1 execute, bit2 cell, bit3 incr, bit4 equal, bit5 edit.
REQ-006 SHALL have port mem_ready  input  1  memory unit idle, no transaction in flight.
REQ-007 SHALL have port sel  output  3  memory mux select code.
REQ-008 SHALL have port grant  output  6  one-hot ownership indication, bit order as req.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port timeout  output  1  sticky flag, set when an owner reaches MAX_HOLD cycles.

Function
REQ-011 SHALL implement three states: IDLE, OWN and DRAIN.
REQ-012 SHALL drive sel = 7 in IDLE, so that the mux drives execute = 0; SHALL drive grant = 0 in IDLE.
REQ-013 SHALL map owner index 0..5 to sel codes 0..5: traversal, execute, cell, incr, equal, edit.
REQ-014 In IDLE with req != 0, SHALL pick the first set bit searching upward from (last+1) mod 6, wrapping after bit 5.
REQ-015 SHALL register the pick into owner and last, and enter OWN on the next edge: grant latency exactly 1 cycle.
REQ-016 SHALL use only the current-cycle req for arbitration; a request withdrawn before it is granted is lost.
REQ-017 In OWN, SHALL drive sel = owner code and grant = one-hot(owner).
REQ-018 SHALL never revoke ownership while req[owner] stays high.
REQ-019 In OWN with req[owner] low and mem_ready high, SHALL go to IDLE.
REQ-020 In OWN with req[owner] low and mem_ready low, SHALL go to DRAIN.
REQ-021 In DRAIN, SHALL hold sel = owner code and drive grant = 0.
REQ-022 In DRAIN, SHALL go to IDLE on the first cycle mem_ready is high.
REQ-023 SHALL ignore req[owner] reassertion during DRAIN; that client re-arbitrates from IDLE.
REQ-024 Handover between owners SHALL cost at least one IDLE cycle (sel = 7).
REQ-025 Hold counter: SHALL clear on entry to OWN, increment each OWN cycle, and saturate at MAX_HOLD.
REQ-026 SHALL set timeout when the hold counter equals MAX_HOLD, and keep it set until reset; ownership is unaffected.
REQ-027 When a grant coincides with a timeout condition on the same edge, timeout SHALL still set.
REQ-028 SHALL register all outputs, with no combinational path from req or mem_ready to any output.

Reset
REQ-029 Asserting rst low SHALL immediately force: IDLE, sel = 7, grant = 0, busy = 0, timeout = 0, hold counter = 0, last = 5 (client 0 gets first priority).
REQ-030 Reset mid-OWN or mid-DRAIN SHALL drop ownership with no drain wait.
REQ-031 The first grant after rst deasserts SHALL occur no earlier than the second rising edge.

Structure
REQ-032 The sel codes (MUX_TRAVERSAL..MUX_EDIT = 0..5, MUX_IDLE = 7) SHALL live in the shared memory_mux header; the state encodings SHALL live in a new memory_arbiter header.
REQ-033 SHALL instantiate one sub-module, rr_pick6: combinational, req[5:0] plus last[2:0] in, valid and index[2:0] out.

Verification
REQ-034 Reset then req = 6'b000100: grant = 6'b000100 and sel = 2 one cycle later; busy = 1.
REQ-035 req = 6'b100001 with last = 5: client 0 is granted. Client 0 drops with mem_ready = 1: IDLE for one cycle, then client 5 is granted, sel = 5.
REQ-036 Owner drops req while mem_ready = 0 for 3 cycles: DRAIN, with sel held and grant = 0, for 3 cycles; IDLE on the cycle mem_ready rises.
REQ-037 MAX_HOLD = 8 and the owner holds for 20 cycles: timeout rises after 8 OWN cycles, grant is unchanged, and timeout stays 1 after release until rst.
REQ-038 rst pulsed low mid-OWN: outputs are sel = 7, grant = 0, busy = 0 asynchronously. With all req high after release, client 0 is granted first, then clients 1,2,3,4,5,0 in turn across successive releases.
